shr_arbiter: RTL and testbench
==============================

# shr_arbiter

Round-robin arbiter sharing one arithmetic right shifter among `NUM_REQ` requesters. Each requester presents a signed operand and shift amount under a valid/ready handshake. One request is granted per cycle, shifted, and returned through a registered output stage tagged with the requester index. Sits beside the accumulator and normalization logic, where several units need occasional sign-preserving right shifts and a dedicated shifter each would waste area.

## Interface

Parameters:

- `WIDTH`, 8: operand width in bits.
- `SHIFT_VAL_WIDTH`, `$clog2(WIDTH+1)`: shift amount width.
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: requester index width.

Ports:

- `clock`  in  1  — sole clock; all state updates on the rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  — bit i: requester i holds a request.
- `req_ready`  out  `NUM_REQ`  — bit i: request i accepted this cycle; one-hot or zero.
- `req_in`  in  `NUM_REQ*WIDTH`  — signed operands; slice i belongs to requester i.
- `req_shift`  in  `NUM_REQ*SHIFT_VAL_WIDTH`  — shift amounts; slice i belongs to requester i.
- `out_valid`  out  1  — result register holds a result.
- `out_ready`  in  1  — consumer accepts the result.
- `out_data`  out  `WIDTH`  — signed result.
- `out_id`  out  `ID_WIDTH`  — index of the requester that produced `out_data`.

## Operation

- **Acceptance.**
  - Internal `accept = !out_valid || out_ready`.
  - Grant candidate g is the first set bit of `req_valid`, scanning from round-robin pointer `ptr` upward with wrap modulo `NUM_REQ`.
  - `req_ready[g] = accept && req_valid[g]`; all other bits are 0.
  - `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `ptr`.
- **Transfer.** A transfer occurs when `req_valid[i] && req_ready[i]`. On a transfer to requester g:
  - `out_data <= req_in[g] >>> req_shift[g]` (sign-fill).
  - `out_id <= g`.
  - `out_valid <= 1`.
  - `ptr <= (g+1) mod NUM_REQ`.
- **Drain without refill.** If `out_valid && out_ready` and no transfer occurs, `out_valid <= 0`. `out_data` and `out_id` hold their values.
- **Stall.** If `out_valid && !out_ready`:
  - No transfer occurs.
  - `out_data`, `out_id`, `out_valid` and `ptr` hold.
- **Pointer.** `ptr` changes only on a transfer. If there are no requests, `ptr` holds.
- **Shift rules.**
  - Shift 0 passes the operand through unchanged.
  - Shift ≥ `WIDTH`, including values above `WIDTH` that fit in `SHIFT_VAL_WIDTH`, yields all bits equal to the operand's sign bit: -1 for a negative operand, 0 otherwise.
- **Requester obligation.** Once `req_valid[i]` is asserted, requester i holds `req_valid[i]`, `req_in[i]` and `req_shift[i]` stable until its transfer completes. The block does not check this.
- **Fairness.** A continuously asserted request is granted within `NUM_REQ` transfers.
- **Reset.**
  - While `resetn` is low: `out_valid=0`, `out_data=0`, `out_id=0`, `ptr=0`, and `req_ready` is all-zero (forced by reset).
  - Reset asserted mid-stream drops the registered result with no output handshake.
  - On the first edge after deassertion the block accepts normally.

## Timing

- Latency: result visible on `out_valid`/`out_data` one cycle after the transfer edge.
- Throughput: one transfer per cycle while `out_ready` stays high. No bubble between back-to-back results, since a simultaneous drain and refill is allowed.
- `out_valid` is registered. `req_ready` is combinational. There is no combinational path from `req_in` or `req_shift` to any output.
- Simultaneous requests: exactly one granted per cycle. The others wait with `req_ready` low.
- `out_ready` low for N cycles: `req_ready` is all-zero for those N cycles; the result and `ptr` are unchanged.

## Test plan

- **Reset values.** Assert `resetn` low mid-stream with `out_valid=1` → immediately `out_valid=0`, `out_data=0`, `out_id=0`, `req_ready=0`. After release, the first grant goes to requester 0 when all requesters are valid.
- **Arithmetic.** Single requester 2, WIDTH=8:
  - `in=8'sb1001_0000` (-112), shift 3 → `out_data=8'sb1111_0010` (-14), `out_id=2`, one cycle later.
  - Shift 0 → unchanged.
  - Shift 8 and shift 15 on -1 → -1.
  - Shift 15 on 127 → 0.
- **Round-robin.** All 4 requesters held valid, `out_ready=1` → grant order 0,1,2,3,0,1… with one result per cycle and no gaps. Drop requester 1 → order 0,2,3,0.
- **Backpressure.** Hold `out_ready=0` for 5 cycles with results pending → `out_data`/`out_id` stable, `req_ready=0` throughout. Raise `out_ready` → the next requester in round-robin order is granted in that same cycle.
- **Drain with no refill.** One request then idle, `out_ready=1` → `out_valid` high for exactly 1 cycle. Afterwards `ptr` equals the granted index + 1.
- **Randomized check.** Random valid/ready/operands for 10k cycles against a scoreboard model:
  - Every accepted request appears exactly once with the correct id and value.
  - No requester waits more than `NUM_REQ` transfers.

Source files
------------

// File: rtl/shr_arbiter.sv
// Round-robin arbiter that shares one arithmetic right shifter among NUM_REQ requesters.
// One grant per cycle; results come back through a registered valid/ready stage tagged with the id.
module shr_arbiter #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SHIFT_VAL_WIDTH = $clog2(WIDTH + 1),
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ID_WIDTH        = $clog2(NUM_REQ)
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_in,
    input  logic [NUM_REQ*SHIFT_VAL_WIDTH-1:0] req_shift,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [ID_WIDTH-1:0]                out_id
);

    logic                       out_valid_q, out_valid_d;
    logic [WIDTH-1:0]           out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]        out_id_q, out_id_d;
    logic [ID_WIDTH-1:0]        ptr_q, ptr_d;

    logic                       accept;
    logic                       grant_found;
    logic [ID_WIDTH-1:0]        grant_idx;
    logic [ID_WIDTH-1:0]        cand_idx;
    logic                       transfer;
    logic [WIDTH-1:0]           sel_op;
    logic [SHIFT_VAL_WIDTH-1:0] sel_shift;
    logic [WIDTH-1:0]           shifted;
    logic [ID_WIDTH-1:0]        ptr_next;

    // (base + off) mod NUM_REQ without relying on NUM_REQ being a power of two.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_WIDTH'(sum);
    endfunction

    assign accept = !out_valid_q || out_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = wrap_add(ptr_q, k);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign transfer = accept && grant_found;

    // Reset forces the handshake low even though the grant logic is combinational.
    always_comb begin
        req_ready = '0;
        if (resetn && transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_shift = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == grant_idx) begin
                sel_op    = req_in[i*WIDTH +: WIDTH];
                sel_shift = req_shift[i*SHIFT_VAL_WIDTH +: SHIFT_VAL_WIDTH];
            end
        end
    end

    // Oversized shifts saturate to the sign fill rather than depending on operator semantics.
    always_comb begin
        shifted = '0;
        if (32'(sel_shift) >= WIDTH) begin
            shifted = {WIDTH{sel_op[WIDTH-1]}};
        end else begin
            shifted = $signed(sel_op) >>> sel_shift;
        end
    end

    assign ptr_next = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = shifted;
            out_id_d    = grant_idx;
            ptr_d       = ptr_next;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_shr_arbiter.sv
// Directed bench for shr_arbiter: stimulus pushes expected results, a monitor pops and compares.
module tb_shr_arbiter;

    logic        clock;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_in;
    logic [15:0] req_shift;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;

    logic [7:0]  op      [4];
    logic [3:0]  sh      [4];
    logic [7:0]  exp_tab [4];

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks;
    int errors;

    assign req_in    = {op[3], op[2], op[1], op[0]};
    assign req_shift = {sh[3], sh[2], sh[1], sh[0]};

    shr_arbiter #(
        .WIDTH   (8),
        .NUM_REQ (4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in    (req_in),
        .req_shift (req_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual id=%0d data=%0h required none",
                         out_id, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_id", 32'(out_id), 32'(e.id));
                chk("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    // Called at posedge+1: drive, check grant at negedge, then return at next posedge+1.
    task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rdy,
                        input int exp_id, input int exp_ov);
        exp_t e;
        req_valid = v;
        out_ready = rdy;
        @(negedge clock);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_ov >= 0) begin
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
        end
        if (exp_rdy != 4'b0000) begin
            e.id   = 2'(exp_id);
            e.data = exp_tab[exp_id];
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    logic [3:0] rr_ready [8];
    logic [3:0] drop_ready [4];
    int         drop_id [4];
    logic [7:0] av_op  [10];
    logic [3:0] av_sh  [10];
    logic [7:0] av_exp [10];

    initial begin
        checks = 0;
        errors = 0;
        op[0] = 8'd40;  sh[0] = 4'd1; exp_tab[0] = 8'h14;
        op[1] = 8'hF8;  sh[1] = 4'd2; exp_tab[1] = 8'hFE;
        op[2] = 8'h90;  sh[2] = 4'd3; exp_tab[2] = 8'hF2;
        op[3] = 8'd100; sh[3] = 4'd0; exp_tab[3] = 8'h64;

        rr_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        drop_ready = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        drop_id    = '{0, 2, 3, 0};
        av_op  = '{8'h90, 8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'h40, 8'h7F, 8'hC4};
        av_sh  = '{4'd3,  4'd0,  4'd8,  4'd15, 4'd15, 4'd7,  4'd8,  4'd6,  4'd8,  4'd2};
        av_exp = '{8'hF2, 8'h5A, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hF1};

        // Reset with every requester valid: nothing may be granted.
        resetn    = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Round-robin with all valid: 0,1,2,3,0,... with no gaps.
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, rr_ready[k], k % 4, (k == 0) ? 0 : 1);
        end
        // Requester 1 dropped: 0,2,3,0.
        for (int k = 0; k < 4; k++) begin
            step(4'b1101, 1'b1, drop_ready[k], drop_id[k], 1);
        end

        // Backpressure: result id0 held, no grants.
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_id", 32'(out_id), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h14);
            @(posedge clock);
            #1;
        end
        step(4'b1111, 1'b1, 4'b0010, 1, 1);

        // Drain without refill, then pointer check.
        step(4'b0000, 1'b1, 4'b0000, 0, 1);
        step(4'b0000, 1'b1, 4'b0000, 0, 0);
        step(4'b0100, 1'b1, 4'b0100, 2, 0);
        step(4'b0000, 1'b1, 4'b0000, 0, 1);
        step(4'b0000, 1'b1, 4'b0000, 0, 0);
        step(4'b1111, 1'b1, 4'b1000, 3, 0);
        step(4'b0000, 1'b1, 4'b0000, 0, 1);

        // Shifter corner cases, back to back on requester 2.
        for (int k = 0; k < 10; k++) begin
            op[2]      = av_op[k];
            sh[2]      = av_sh[k];
            exp_tab[2] = av_exp[k];
            step(4'b0100, 1'b1, 4'b0100, 2, -1);
        end
        step(4'b0000, 1'b1, 4'b0000, 0, 1);
        op[2] = 8'h90; sh[2] = 4'd3; exp_tab[2] = 8'hF2;

        // Mid-stream reset drops the pending result.
        step(4'b0010, 1'b1, 4'b0010, 1, 0);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        resetn    = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_data", 32'(out_data), 32'd0);
        chk("mrst_out_id", 32'(out_id), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        step(4'b1111, 1'b1, 4'b0001, 0, 0);
        step(4'b0000, 1'b1, 4'b0000, 0, 1);
        step(4'b0000, 1'b1, 4'b0000, 0, 0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
